// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the multi-cycle divider.
// EX drives the master side; the divider sits on the slave side.
interface div_unit_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider, one quotient bit per cycle.
// Result is {remainder, quotient}; signed mode divides magnitudes and fixes signs at the end.
//
// state  | meaning
// FREE   | idle, waiting for an un-annulled start
// BYZERO | divisor was zero, answer 0 next cycle
// ON     | 32 restoring steps in progress
// END    | result valid, held until start drops
module div_unit (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        qsign_q, qsign_d;
    logic        rsign_q, rsign_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [64:0] shifted;
    logic [32:0] trial_hi;
    logic [32:0] diff;
    logic        ge;
    logic [64:0] step_val;
    logic [31:0] abs1, abs2;

    assign shifted  = {work_q[63:0], 1'b0};
    assign trial_hi = shifted[64:32];
    assign ge       = trial_hi >= {1'b0, divisor_q};
    assign diff     = trial_hi - {1'b0, divisor_q};
    assign step_val = ge ? {diff, shifted[31:1], 1'b1} : shifted;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is correct as unsigned.
    assign abs1 = (bus.signed_div_i && bus.opdata1_i[31]) ? 32'd0 - bus.opdata1_i : bus.opdata1_i;
    assign abs2 = (bus.signed_div_i && bus.opdata2_i[31]) ? 32'd0 - bus.opdata2_i : bus.opdata2_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        result_d  = result_q;
        ready_d   = ready_q;
        case (state_q)
            FREE: begin
                result_d = 64'd0;
                ready_d  = 1'b0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == 32'd0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d   = ON;
                        cnt_d     = 6'd0;
                        work_d    = {33'd0, abs1};
                        divisor_d = abs2;
                        qsign_d   = bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                        rsign_d   = bus.signed_div_i & bus.opdata1_i[31];
                    end
                end
            end
            BYZERO: begin
                if (bus.annul_i) begin
                    state_d = FREE;
                end else begin
                    state_d  = END;
                    result_d = 64'd0;
                    ready_d  = 1'b1;
                end
            end
            ON: begin
                if (bus.annul_i) begin
                    state_d = FREE;
                    cnt_d   = 6'd0;
                end else begin
                    work_d = step_val;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d  = END;
                        ready_d  = 1'b1;
                        result_d = {rsign_q ? 32'd0 - step_val[63:32] : step_val[63:32],
                                    qsign_q ? 32'd0 - step_val[31:0]  : step_val[31:0]};
                    end
                end
            end
            END: begin
                if (bus.annul_i || !bus.start_i) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FREE;
            cnt_q     <= 6'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized requests
// compared against an arithmetic reference model.
module tb_div_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    div_unit_if bus();
    div_unit dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division; / truncates toward zero, % follows the dividend.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raises start and waits for ready; lat counts edges from acceptance (edge 1) to ready.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        lat = -1;
        res = 64'd0;
        for (int i = 1; i <= 45; i++) begin
            step();
            if (bus.ready_o === 1'b1) begin
                lat = i;
                res = bus.result_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd0;
        bus.opdata2_i = 32'd0;
        step();
        step();
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=0", bus.ready_o);
        end
        checks++;
        if (bus.result_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_result got=%h exp=0", bus.result_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_unsigned();
        logic [63:0] res;
        int lat;
        do_div(1'b0, 32'd100, 32'd7, res, lat);
        checks++;
        if (lat != 33) begin
            errors++;
            $display("FAIL udiv_latency got=%0d exp=33", lat);
        end
        checks++;
        if (res !== 64'h00000002_0000000E) begin
            errors++;
            $display("FAIL udiv_result got=%h exp=000000020000000e", res);
        end
        // start held across END must keep the result, not start a new divide
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000002_0000000E) begin
            errors++;
            $display("FAIL udiv_hold got=%b/%h exp=1/000000020000000e", bus.ready_o, bus.result_o);
        end
        bus.start_i = 1'b0;
        step();
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errors++;
            $display("FAIL udiv_drop got=%b/%h exp=0/0", bus.ready_o, bus.result_o);
        end
    endtask

    task automatic test_directed(input string name, input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
        logic [63:0] res;
        int lat;
        do_div(sgn, a, b, res, lat);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat);
        end
        checks++;
        if (res !== exp_res) begin
            errors++;
            $display("FAIL %s_result got=%h exp=%h", name, res, exp_res);
        end
        bus.start_i = 1'b0;
        step();
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errors++;
            $display("FAIL %s_drop got=%b/%h exp=0/0", name, bus.ready_o, bus.result_o);
        end
    endtask

    task automatic test_signed();
        test_directed("sdiv_neg7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
        test_directed("sdiv_7_neg2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    endtask

    task automatic test_div_zero();
        test_directed("zero_signed", 1'b1, 32'h12345678, 32'd0, 64'd0, 2);
        test_directed("zero_unsigned", 1'b0, 32'h12345678, 32'd0, 64'd0, 2);
    endtask

    task automatic test_edge();
        test_directed("min_by_neg1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
        test_directed("umax_by_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33);
        test_directed("u3_by_umax", 1'b0, 32'd3, 32'hFFFFFFFF, 64'h00000003_00000000, 33);
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int lat;
        bit seen;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i = 1'b1;
        step();                       // acceptance
        for (int i = 0; i < 10; i++) step();
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        step();
        bus.annul_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.ready_o !== 1'b0) seen = 1'b1;
            step();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL annul_on_ready got=1 exp=0");
        end
        test_directed("after_annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

        // annul together with start in FREE: no request may be accepted
        bus.opdata2_i = 32'd7;
        bus.start_i = 1'b1;
        bus.annul_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.ready_o !== 1'b0) seen = 1'b1;
            step();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL annul_free_ready got=1 exp=0");
        end

        // annul in END clears outputs even with start still high
        do_div(1'b0, 32'd50, 32'd5, res, lat);
        checks++;
        if (lat != 33 || res !== 64'h00000000_0000000A) begin
            errors++;
            $display("FAIL annul_end_pre got=%0d/%h exp=33/000000000000000a", lat, res);
        end
        bus.annul_i = 1'b1;
        step();
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errors++;
            $display("FAIL annul_end got=%b/%h exp=0/0", bus.ready_o, bus.result_o);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bit seen;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'h0000DEAD;
        bus.opdata2_i = 32'd3;
        bus.start_i = 1'b1;
        step();
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        bus.start_i = 1'b0;
        step();
        rst = 1'b0;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errors++;
            $display("FAIL rst_mid_out got=%b/%h exp=0/0", bus.ready_o, bus.result_o);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.ready_o !== 1'b0) seen = 1'b1;
            step();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_mid_ready got=1 exp=0");
        end
        test_directed("after_rst", 1'b0, 32'd81, 32'd9, 64'h00000000_00000009, 33);
    endtask

    task automatic test_random();
        logic [63:0] res, exp_res;
        logic [31:0] a, b;
        logic sgn;
        int lat, exp_lat;
        for (int n = 0; n < 40; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = 32'd0 - 32'($urandom_range(1, 15));
                default: ;
            endcase
            exp_res = model(sgn, a, b);
            exp_lat = (b == 32'd0) ? 2 : 33;
            do_div(sgn, a, b, res, lat);
            checks++;
            if (lat != exp_lat || res !== exp_res) begin
                errors++;
                $display("FAIL rand_%0d s=%b a=%h b=%h got=%0d/%h exp=%0d/%h",
                         n, sgn, a, b, lat, res, exp_lat, exp_res);
            end
            bus.start_i = 1'b0;
            step();
            checks++;
            if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
                errors++;
                $display("FAIL rand_drop_%0d got=%b/%h exp=0/0", n, bus.ready_o, bus.result_o);
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        #1;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_edge();
        test_annul();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
